mem_req_master: RTL and testbench
=================================

Name: mem_req_master

Overview:
- Initiator-side engine for the single-port synchronous memory (addr/wr_en/rd_en/wdata/rdata protocol).
- Accepts read/write commands from a valid/ready request port and buffers them in a small FIFO.
- Issues the commands to the memory one at a time, in order.
- Returns read data on a valid/ready response port. Writes produce no response.

Parameters:
- ADDR_W, 4, memory address width.
- DATA_W, 8, memory data width.
- RD_LAT, 1, cycles from the rd_en cycle to the cycle in which the memory's rdata is valid; legal range 1..7.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2, at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req_valid  in  1  command present.
- req_ready  out  1  command FIFO not full.
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  command address.
- req_wdata  in  DATA_W  write data; ignored for reads.
- rsp_valid  out  1  read response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data.
- rsp_addr  out  ADDR_W  address the read data came from.
- addr  out  ADDR_W  memory address.
- wr_en  out  1  memory write strobe.
- rd_en  out  1  memory read strobe.
- wdata  out  DATA_W  memory write data.
- rdata  in  DATA_W  memory read data.
- busy  out  1  FIFO non-empty or FSM not in IDLE.

Behaviour:
- Reset values (reset==0 at posedge): all outputs 0 except req_ready=1. FSM enters IDLE, FIFO is emptied, wait counter cleared, command register cleared.
- Request handshake:
  - A request is accepted on a posedge where req_valid && req_ready; its fields are pushed into the FIFO.
  - req_ready = !full, computed from registered FIFO state.
  - A push is refused when the FIFO is full, even if a pop occurs in the same cycle.
- FSM states: IDLE, ISSUE_WR, ISSUE_RD, RD_WAIT, RSP.
- IDLE:
  - If the FIFO is non-empty: pop the head into the command register {write, addr, wdata}.
  - Next state is ISSUE_WR if write, otherwise ISSUE_RD.
  - If the FIFO is empty: stay in IDLE.
- ISSUE_WR: wr_en=1 for exactly this cycle, then go to IDLE.
- ISSUE_RD: rd_en=1 for exactly this cycle; load the wait counter with RD_LAT; go to RD_WAIT.
- RD_WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 1: register rdata into rsp_rdata and the command address into rsp_addr, then go to RSP.
- RSP:
  - rsp_valid=1. rsp_rdata and rsp_addr are held stable until rsp_ready is high.
  - On the handshake, go to IDLE; rsp_valid drops the next cycle.
- addr and wdata are always driven from the command register. They hold their last value when idle.
- wr_en and rd_en are never high together, and each is high at most one cycle per command.
- Latency, with a request accepted at the edge ending cycle 0 and the FIFO empty:
  - Pop occurs in cycle 1.
  - Write: wr_en high in cycle 2.
  - Read: rd_en high in cycle 2; rsp_valid rises in cycle 3+RD_LAT (cycle 4 when RD_LAT=1).
- Throughput:
  - A write occupies 2 cycles.
  - A read occupies 3+RD_LAT cycles plus any response stall.
  - Only one read is outstanding at a time; commands are strictly in order.
  - The FIFO keeps accepting requests while the FSM is stalled in RSP.
- FIFO pointers are (log2 FIFO_DEPTH)+1 bits wide, with wrap-around; full and empty are decided by the MSB comparison.
- Write then read to the same address: the read is issued after the write cycle, so it returns the new data.
- Reset asserted mid-operation: everything is cleared on that edge. A pending read is dropped with no response, and a queued write is discarded without being issued.

Decomposition:
- Package mem_req_pkg: state enum typedef (IDLE, ISSUE_WR, ISSUE_RD, RD_WAIT, RSP); packed struct cmd_t {write, addr, wdata}, parameterised through package-level default widths.
- Sub-module cmd_fifo: synchronous FIFO of cmd_t with push, pop, full and empty. It uses the same clk and the same active-low synchronous reset.

Test Plan:
1. Reset: hold reset=0 for 2 cycles, then release → req_ready=1, all other outputs 0, busy=0.
2. Single write: write addr=3, wdata=8'hA5, accepted in cycle 0 → cycle 2 has wr_en=1, addr=3, wdata=A5; wr_en=0 otherwise; rsp_valid never rises.
3. Write then read (RD_LAT=1): write 5/8'h3C, then read 5 with rsp_ready=1 → rsp_valid in a single cycle with rsp_rdata=3C, rsp_addr=5.
4. FIFO full with response stall: rsp_ready=0; push 1 read + 4 writes back to back → req_ready=0 after the FIFO fills; the FSM holds in RSP with data stable. Raise rsp_ready → the queued writes issue in order, every 2 cycles.
5. RD_LAT=3 build: read addr=0xF (memory holds 8'h77) → rd_en in cycle 2, rsp_valid in cycle 6, rsp_rdata=77.
6. Reset mid-read: assert reset in the RD_WAIT cycle → no rsp_valid ever; FIFO empty; busy=0 on the next cycle.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types for the memory request master: FSM state encoding and the
// command record carried through the command FIFO.
package mem_req_pkg;

    localparam int CMD_ADDR_W = 4;
    localparam int CMD_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_WR,
        ISSUE_RD,
        RD_WAIT,
        RSP
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are told apart by the MSB.
module cmd_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout  = mem[rp[AW-1:0]];

    // Push is gated on the registered full flag only, so a same-cycle pop
    // never frees a slot for the incoming command.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full) begin
                mem[wp[AW-1:0]] <= din;
                wp              <= wp + 1'b1;
            end
            if (pop && !empty) begin
                rp <= rp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_master.sv
// Initiator engine: queues read/write commands and issues them one at a time,
// in order, to a single-port synchronous memory; read data returns on rsp_*.
module mem_req_master
    import mem_req_pkg::*;
#(
    parameter int ADDR_W     = CMD_ADDR_W,
    parameter int DATA_W     = CMD_DATA_W,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [ADDR_W-1:0] addr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic              busy
);

    state_t     state;
    cmd_t       push_cmd;
    cmd_t       head;
    cmd_t       cmd_q;
    logic       fifo_full;
    logic       fifo_empty;
    logic       pop;
    logic [2:0] cnt;

    assign push_cmd  = '{write: req_write, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign addr      = cmd_q.addr;
    assign wdata     = cmd_q.wdata;
    assign busy      = !fifo_empty || (state != IDLE);

    cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (req_valid),
        .din   (push_cmd),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Strobes are registered on the pop so they line up with the freshly
    // loaded command register in the ISSUE_* cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cmd_q     <= '0;
            cnt       <= '0;
            wr_en     <= 1'b0;
            rd_en     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_q <= head;
                        wr_en <= head.write;
                        rd_en <= !head.write;
                        state <= head.write ? ISSUE_WR : ISSUE_RD;
                    end
                end
                ISSUE_WR: begin
                    wr_en <= 1'b0;
                    state <= IDLE;
                end
                ISSUE_RD: begin
                    rd_en <= 1'b0;
                    cnt   <= 3'(RD_LAT);
                    state <= RD_WAIT;
                end
                RD_WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        rsp_rdata <= rdata;
                        rsp_addr  <= cmd_q.addr;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench: two masters (RD_LAT=1 and RD_LAT=3) share the request
// stimulus, each with its own behavioural memory of matching read latency.
module tb_mem_req_master;

    logic       clk;
    logic       reset;
    logic       req_valid;
    logic       req_write;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_ready;

    logic       req_ready_1, rsp_valid_1, wr_en_1, rd_en_1, busy_1;
    logic [7:0] rsp_rdata_1, wdata_1, rdata_1;
    logic [3:0] rsp_addr_1, addr_1;
    logic       req_ready_3, rsp_valid_3, wr_en_3, rd_en_3, busy_3;
    logic [7:0] rsp_rdata_3, wdata_3, rdata_3;
    logic [3:0] rsp_addr_3, addr_3;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] WD [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    mem_req_master #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_1),
        .rsp_addr(rsp_addr_1), .addr(addr_1), .wr_en(wr_en_1), .rd_en(rd_en_1),
        .wdata(wdata_1), .rdata(rdata_1), .busy(busy_1)
    );

    mem_req_master #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_3),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_3),
        .rsp_addr(rsp_addr_3), .addr(addr_3), .wr_en(wr_en_3), .rd_en(rd_en_3),
        .wdata(wdata_3), .rdata(rdata_3), .busy(busy_3)
    );

    // Memories: read data appears RD_LAT cycles after the rd_en cycle.
    logic [7:0] mem1 [16];
    logic [7:0] mem3 [16];
    logic [7:0] p1;
    logic [7:0] p3 [3];

    always @(posedge clk) begin
        if (wr_en_1) mem1[addr_1] <= wdata_1;
        p1 <= mem1[addr_1];
        if (wr_en_3) mem3[addr_3] <= wdata_3;
        p3[0] <= mem3[addr_3];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign rdata_1 = p1;
    assign rdata_3 = p3[2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [3:0] a, input logic [7:0] d);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    initial begin
        reset = 1'b0;
        rsp_ready = 1'b0;
        idle();

        // 1: reset
        step(); step();
        reset = 1'b1;
        chk("rst_req_ready", 32'(req_ready_1), 1);
        chk("rst_rsp_valid", 32'(rsp_valid_1), 0);
        chk("rst_wr_en",     32'(wr_en_1), 0);
        chk("rst_rd_en",     32'(rd_en_1), 0);
        chk("rst_addr",      32'(addr_1), 0);
        chk("rst_rsp_rdata", 32'(rsp_rdata_1), 0);
        chk("rst_busy",      32'(busy_1), 0);
        chk("rst_req_ready3",32'(req_ready_3), 1);

        // 2: single write
        drive(1'b1, 4'h3, 8'hA5);
        step(); idle();
        chk("wr_c1_busy",  32'(busy_1), 1);
        chk("wr_c1_wr_en", 32'(wr_en_1), 0);
        step();
        chk("wr_c2_wr_en", 32'(wr_en_1), 1);
        chk("wr_c2_addr",  32'(addr_1), 32'h3);
        chk("wr_c2_wdata", 32'(wdata_1), 32'hA5);
        chk("wr_c2_rd_en", 32'(rd_en_1), 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wr_after_wr_en", 32'(wr_en_1), 0);
            chk("wr_no_rsp",      32'(rsp_valid_1), 0);
        end
        chk("wr_busy_done", 32'(busy_1), 0);

        // 3: write then read same address
        rsp_ready = 1'b1;
        drive(1'b1, 4'h5, 8'h3C);
        step();
        drive(1'b0, 4'h5, 8'h00);
        step(); idle();
        chk("wr_rd_c2_wr_en", 32'(wr_en_1), 1);
        step(); step();
        chk("wr_rd_c4_rd_en", 32'(rd_en_1), 1);
        chk("wr_rd_c4_addr",  32'(addr_1), 32'h5);
        chk("wr_rd_c4_wr_en", 32'(wr_en_1), 0);
        step();
        chk("wr_rd_c5_rsp", 32'(rsp_valid_1), 0);
        step();
        chk("wr_rd_c6_rsp",   32'(rsp_valid_1), 1);
        chk("wr_rd_c6_rdata", 32'(rsp_rdata_1), 32'h3C);
        chk("wr_rd_c6_raddr", 32'(rsp_addr_1), 32'h5);
        step();
        chk("wr_rd_c7_rsp",  32'(rsp_valid_1), 0);
        chk("wr_rd_c7_busy", 32'(busy_1), 0);

        // 4: FIFO fills behind a stalled response
        rsp_ready = 1'b0;
        drive(1'b0, 4'h5, 8'h00);
        chk("full_rdy_r", 32'(req_ready_1), 1);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'(8 + i), WD[i]);
            chk("full_rdy_w", 32'(req_ready_1), 1);
            step();
        end
        drive(1'b1, 4'hC, 8'h55);
        chk("full_req_ready", 32'(req_ready_1), 0);
        chk("full_rsp_valid", 32'(rsp_valid_1), 1);
        chk("full_rsp_rdata", 32'(rsp_rdata_1), 32'h3C);
        chk("full_rsp_addr",  32'(rsp_addr_1), 32'h5);
        for (int j = 0; j < 3; j++) begin
            step(); idle();
            chk("stall_rsp_valid", 32'(rsp_valid_1), 1);
            chk("stall_rsp_rdata", 32'(rsp_rdata_1), 32'h3C);
            chk("stall_req_ready", 32'(req_ready_1), 0);
            chk("stall_wr_en",     32'(wr_en_1), 0);
        end
        rsp_ready = 1'b1;
        step();
        chk("drain_rsp_drop", 32'(rsp_valid_1), 0);
        chk("drain_busy",     32'(busy_1), 1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("drain_wr_en", 32'(wr_en_1), 1);
            chk("drain_addr",  32'(addr_1), 32'(8 + k));
            chk("drain_wdata", 32'(wdata_1), 32'(WD[k]));
            chk("drain_rdy",   32'(req_ready_1), 1);
            step();
            chk("drain_gap", 32'(wr_en_1), 0);
        end
        chk("drain_idle", 32'(busy_1), 0);

        // 6: reset during RD_WAIT drops the read and a queued write
        drive(1'b0, 4'h8, 8'h00);
        step();
        drive(1'b1, 4'hD, 8'h99);
        step(); idle();
        chk("rrst_c2_rd_en", 32'(rd_en_1), 1);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("rrst_busy",      32'(busy_1), 0);
        chk("rrst_req_ready", 32'(req_ready_1), 1);
        chk("rrst_rsp_valid", 32'(rsp_valid_1), 0);
        chk("rrst_addr",      32'(addr_1), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("rrst_no_rsp", 32'(rsp_valid_1), 0);
            chk("rrst_no_wr",  32'(wr_en_1), 0);
        end

        // 5: RD_LAT=3 read of address F holding 8'h77
        drive(1'b1, 4'hF, 8'h77);
        step(); idle();
        step();
        chk("lat3_wr_en", 32'(wr_en_3), 1);
        step(); step();
        drive(1'b0, 4'hF, 8'h00);
        step(); idle();
        step();
        chk("lat3_c2_rd_en", 32'(rd_en_3), 1);
        chk("lat3_c2_addr",  32'(addr_3), 32'hF);
        for (int c = 3; c < 6; c++) begin
            step();
            chk("lat3_no_rsp_yet", 32'(rsp_valid_3), 0);
            if (c == 4) chk("lat1_c4_rdata", 32'(rsp_rdata_1), 32'h77);
        end
        step();
        chk("lat3_c6_rsp",   32'(rsp_valid_3), 1);
        chk("lat3_c6_rdata", 32'(rsp_rdata_3), 32'h77);
        chk("lat3_c6_raddr", 32'(rsp_addr_3), 32'hF);
        step();
        chk("lat3_c7_rsp", 32'(rsp_valid_3), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
